lamp_fpu_tay_rnd_pack: RTL and testbench

// Round-and-pack stage directly downstream of the Taylor-path multiplier.

---
 rtl/lamp_fpu_tay_rnd_pack_pkg.sv | 26 ++
 rtl/lamp_fpu_pipe_reg.sv | 39 +++
 rtl/lamp_fpu_tay_rnd_pack.sv | 133 +++++++++++++
 tb/tb_lamp_fpu_tay_rnd_pack.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lamp_fpu_tay_rnd_pack_pkg.sv
// Shared constants, flag type and round-to-nearest-even helper for the
// Taylor-path round-and-pack stage.
package taylor_pkg;

  localparam int unsigned LAMP_FLOAT_F_DW = 7;
  localparam int unsigned LAMP_FLOAT_E_DW = 8;
  localparam logic [LAMP_FLOAT_E_DW-1:0] LAMP_FLOAT_E_MAX = '1;

  // Bit positions of the rounding fields at the bottom of the multiplier's f word.
  localparam int unsigned IDX_S   = 0;
  localparam int unsigned IDX_R   = 1;
  localparam int unsigned IDX_G   = 2;
  localparam int unsigned IDX_LSB = 3;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic nx;
  } rnd_flags_t;

  function automatic logic FUNC_rndInc(input logic lsb, input logic g,
                                       input logic r, input logic s);
    return g & (r | s | lsb);
  endfunction

endpackage

// File: rtl/lamp_fpu_pipe_reg.sv
// One valid/ready register slice: accepts when empty or when its content
// drains in the same cycle, so back-to-back transfers run without bubbles.
module lamp_fpu_pipe_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ready_i
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_load;

  assign ready_o = !r_valid || ready_i;
  assign w_load  = valid_i && ready_o;
  assign valid_o = r_valid;
  assign data_o  = r_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of block order.
  // NOTE: the data register is reset as well because the packed result must
  // read zero out of reset; a pure datapath slice would normally skip it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (ready_o) r_valid <= valid_i;
      if (w_load)  r_data  <= data_i;
    end
  end

endmodule

// File: rtl/lamp_fpu_tay_rnd_pack.sv
// Round-to-nearest-even and pack of the Taylor-path multiplier result into a
// 1+E_DW+F_DW float, two valid/ready stages, sticky {ovf, unf, nx} flags.
module lamp_fpu_tay_rnd_pack
  import taylor_pkg::*;
#(
  parameter int unsigned F_DW = LAMP_FLOAT_F_DW,
  parameter int unsigned E_DW = LAMP_FLOAT_E_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   s_i,
  input  logic [E_DW-1:0]        e_i,
  input  logic [F_DW+4:0]        f_i,
  input  logic                   isToRound_i,
  input  logic                   isOverflow_i,
  input  logic                   isUnderflow_i,
  output logic [E_DW+F_DW:0]     res_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  input  logic                   clr_flags_i,
  output logic [2:0]             flags_o
);

  localparam int unsigned        RES_W = 1 + E_DW + F_DW;
  localparam logic [E_DW-1:0]    E_MAX = {E_DW{1'b1}};

  typedef struct packed {
    logic            s;
    logic [E_DW-1:0] e;
    logic [F_DW:0]   mant;
    logic            inc;
    logic            to_round;
    logic            ovf;
    logic            unf;
    logic            nx;
  } s1_t;

  s1_t               w_s1_d, w_s1_q;
  logic              w_v1, w_s2_rdy, w_s2_load;
  logic [F_DW+1:0]   w_m;
  logic [E_DW-1:0]   w_e_rnd;
  logic [F_DW-1:0]   w_frac;
  logic              w_ovf;
  logic [RES_W-1:0]  w_res;
  rnd_flags_t        w_flags, r_flags;
  logic              w_unused_f_ovf;

  // The mantissa overflow bit is already normalised away upstream; isOverflow_i carries it.
  assign w_unused_f_ovf = f_i[F_DW+4];

  always_comb begin
    w_s1_d          = '0;
    w_s1_d.s        = s_i;
    w_s1_d.e        = e_i;
    w_s1_d.mant     = f_i[F_DW+3:IDX_LSB];
    w_s1_d.inc      = isToRound_i && !isOverflow_i &&
                      FUNC_rndInc(f_i[IDX_LSB], f_i[IDX_G], f_i[IDX_R], f_i[IDX_S]);
    w_s1_d.to_round = isToRound_i;
    w_s1_d.nx       = isToRound_i && (|f_i[IDX_G:IDX_S]);
    w_s1_d.ovf      = isToRound_i && isOverflow_i;
    w_s1_d.unf      = isToRound_i && (isUnderflow_i || (e_i == '0 && (|f_i[IDX_G:IDX_S])));
  end

  lamp_fpu_pipe_reg #(.WIDTH($bits(s1_t))) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (w_s1_d),
    .valid_o (w_v1),
    .data_o  (w_s1_q),
    .ready_i (w_s2_rdy)
  );

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_m     = {1'b0, w_s1_q.mant} + {{(F_DW+1){1'b0}}, w_s1_q.inc};
    w_e_rnd = w_s1_q.e;
    w_frac  = w_m[F_DW-1:0];
    if (w_m[F_DW+1]) begin
      w_e_rnd = w_s1_q.e + E_DW'(1);
      w_frac  = w_m[F_DW:1];
    end else if (w_s1_q.e == '0 && w_m[F_DW]) begin
      // Rounding lifted a denormal into the normal range.
      w_e_rnd = E_DW'(1);
    end

    w_ovf = w_s1_q.to_round &&
            (w_s1_q.ovf || w_s1_q.e == E_MAX || w_e_rnd == E_MAX);

    w_flags.ovf = w_ovf;
    w_flags.unf = w_s1_q.unf;
    w_flags.nx  = w_s1_q.nx;

    w_res = {w_s1_q.s, w_e_rnd, w_frac};
    if (!w_s1_q.to_round) begin
      w_res   = {w_s1_q.s, w_s1_q.e, w_s1_q.mant[F_DW-1:0]};
      w_flags = '0;
    end else if (w_ovf) begin
      w_res = {w_s1_q.s, E_MAX, {F_DW{1'b0}}};
    end
  end

  lamp_fpu_pipe_reg #(.WIDTH(RES_W)) u_stage2 (
    .clk     (clk),
    .rst     (rst),
    .valid_i (w_v1),
    .ready_o (w_s2_rdy),
    .data_i  (w_res),
    .valid_o (valid_o),
    .data_o  (res_o),
    .ready_i (ready_i)
  );

  assign w_s2_load = w_v1 && w_s2_rdy;

  // A clear coinciding with a load keeps only the newly loaded flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flags <= '0;
    end else if (w_s2_load) begin
      r_flags <= clr_flags_i ? w_flags : (r_flags | w_flags);
    end else if (clr_flags_i) begin
      r_flags <= '0;
    end
  end

  assign flags_o = r_flags;

endmodule

// File: tb/tb_lamp_fpu_tay_rnd_pack.sv
// Self-checking bench for lamp_fpu_tay_rnd_pack: directed vector table,
// multi-cycle corner sequences and randomized traffic against a reference model.
module tb_lamp_fpu_tay_rnd_pack;

  logic        clk;
  logic        rst;
  logic        valid_i, ready_o;
  logic        s_i;
  logic [7:0]  e_i;
  logic [11:0] f_i;
  logic        isToRound_i, isOverflow_i, isUnderflow_i;
  logic [15:0] res_o;
  logic        valid_o, ready_i, clr_flags_i;
  logic [2:0]  flags_o;

  lamp_fpu_tay_rnd_pack dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .s_i           (s_i),
    .e_i           (e_i),
    .f_i           (f_i),
    .isToRound_i   (isToRound_i),
    .isOverflow_i  (isOverflow_i),
    .isUnderflow_i (isUnderflow_i),
    .res_o         (res_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .clr_flags_i   (clr_flags_i),
    .flags_o       (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [11:0] f;
    logic        tr, ov, un;
    logic [15:0] res;
    logic [2:0]  flg;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: value-level RNE rounding and packing for bfloat16.
  function automatic void model(input logic s, input logic [7:0] e, input logic [11:0] f,
                                input logic tr, input logic ov, input logic un,
                                output logic [15:0] res, output logic [2:0] flg);
    int   m, ee;
    logic inc, nx, unf;
    if (!tr) begin
      res = {s, e, f[9:3]};
      flg = 3'b000;
      return;
    end
    inc = !ov && f[2] && (f[1] || f[0] || f[3]);
    m   = int'(f[10:3]) + (inc ? 1 : 0);
    ee  = int'(e);
    if (m >= 256) begin
      ee = ee + 1;
      m  = m / 2;
    end else if (ee == 0 && m >= 128) begin
      ee = 1;
    end
    nx  = (f[2:0] != 3'b000);
    unf = un || (e == 8'h00 && nx);
    if (ov || ee >= 255) begin
      res = {s, 8'hFF, 7'h00};
      flg = {1'b1, unf, nx};
    end else begin
      res = {s, 8'(ee), 7'(m)};
      flg = {1'b0, unf, nx};
    end
  endfunction

  task automatic set_in(input vec_t v, input logic vld);
    valid_i       = vld;
    s_i           = v.s;
    e_i           = v.e;
    f_i           = v.f;
    isToRound_i   = v.tr;
    isOverflow_i  = v.ov;
    isUnderflow_i = v.un;
  endtask

  task automatic clear_flags(input string nm);
    @(negedge clk);
    clr_flags_i = 1'b1;
    @(negedge clk);
    clr_flags_i = 1'b0;
    #1;
    check({nm, "_clr"}, 32'(flags_o), 32'h0);
  endtask

  // One isolated transfer; latency counted in clock edges from presentation.
  task automatic run_one(input vec_t v, input string nm);
    int lat;
    @(negedge clk);
    set_in(v, 1'b1);
    #1;
    check({nm, "_ready"}, 32'(ready_o), 32'h1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'd2);
    check({nm, "_res"}, 32'(res_o), 32'(v.res));
    check({nm, "_flags"}, 32'(flags_o), 32'(v.flg));
  endtask

  vec_t        tbl[10];
  vec_t        rv;
  logic [15:0] q[$];
  logic [15:0] exp_res;
  logic [2:0]  exp_flg, acc_flg;

  initial begin
    tbl[0] = '{s:1'b0, e:8'h7F, f:12'h404, tr:1'b1, ov:1'b0, un:1'b0, res:16'h3F80, flg:3'b001};
    tbl[1] = '{s:1'b0, e:8'h7F, f:12'h40C, tr:1'b1, ov:1'b0, un:1'b0, res:16'h3F82, flg:3'b001};
    tbl[2] = '{s:1'b0, e:8'h7F, f:12'h7FE, tr:1'b1, ov:1'b0, un:1'b0, res:16'h4000, flg:3'b001};
    tbl[3] = '{s:1'b0, e:8'hFE, f:12'h7FE, tr:1'b1, ov:1'b0, un:1'b0, res:16'h7F80, flg:3'b101};
    tbl[4] = '{s:1'b0, e:8'h7F, f:12'h405, tr:1'b1, ov:1'b0, un:1'b0, res:16'h3F81, flg:3'b001};
    tbl[5] = '{s:1'b0, e:8'h00, f:12'h3FE, tr:1'b1, ov:1'b0, un:1'b0, res:16'h0080, flg:3'b011};
    tbl[6] = '{s:1'b0, e:8'hFF, f:12'h600, tr:1'b0, ov:1'b0, un:1'b0, res:16'h7FC0, flg:3'b000};
    tbl[7] = '{s:1'b1, e:8'h50, f:12'h40C, tr:1'b1, ov:1'b1, un:1'b0, res:16'hFF80, flg:3'b101};
    tbl[8] = '{s:1'b0, e:8'h01, f:12'h400, tr:1'b1, ov:1'b0, un:1'b1, res:16'h0080, flg:3'b010};
    tbl[9] = '{s:1'b0, e:8'h85, f:12'h5A8, tr:1'b1, ov:1'b0, un:1'b0, res:16'h42B5, flg:3'b000};

    rst = 1'b0;
    ready_i = 1'b1;
    clr_flags_i = 1'b0;
    set_in(tbl[0], 1'b0);
    repeat (2) @(negedge clk);
    check("rst_valid_o", 32'(valid_o), 32'h0);
    check("rst_res_o", 32'(res_o), 32'h0);
    check("rst_flags_o", 32'(flags_o), 32'h0);
    rst = 1'b1;
    #1;
    check("rst_ready_o", 32'(ready_o), 32'h1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i], $sformatf("vec%0d", i));
      clear_flags($sformatf("vec%0d", i));
    end

    // Clear landing on the same edge as a flag update: the new flags survive.
    run_one(tbl[3], "sticky_set");
    @(negedge clk);
    set_in(tbl[0], 1'b1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clr_flags_i = 1'b1;
    @(posedge clk);
    #1;
    clr_flags_i = 1'b0;
    check("clr_vs_update_flags", 32'(flags_o), 32'(3'b001));
    check("clr_vs_update_res", 32'(res_o), 32'h3F80);
    clear_flags("clr_vs_update");

    // Backpressure: four back-to-back inputs, downstream stalled for 3 cycles.
    begin
      int sent, got, cyc;
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 4 && cyc < 40) begin
        @(negedge clk);
        ready_i = (cyc >= 3);
        if (sent < 4) set_in(tbl[sent], 1'b1);
        else valid_i = 1'b0;
        #1;
        if (cyc == 2) begin
          check("bp_accepted_before_stall", 32'(sent), 32'd2);
          check("bp_ready_low", 32'(ready_o), 32'h0);
        end
        if (valid_o && ready_i) begin
          check($sformatf("bp_out%0d", got), 32'(res_o), 32'(tbl[got].res));
          got++;
        end
        if (valid_i && ready_o) sent++;
        cyc++;
      end
      check("bp_all_out", 32'(got), 32'd4);
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(negedge clk);
      check("bp_no_duplicate", 32'(valid_o), 32'h0);
    end
    clear_flags("bp");

    // Randomized traffic with random stalls against the reference model.
    begin
      int n_in, n_out;
      n_in = 0;
      n_out = 0;
      acc_flg = 3'b000;
      for (int cyc = 0; cyc < 4000 && (n_in < 300 || q.size() > 0); cyc++) begin
        @(negedge clk);
        if (n_in < 300 && $urandom_range(0, 3) != 0) begin
          rv.s = 1'($urandom);
          case ($urandom_range(0, 9))
            0: rv.e = 8'h00;
            1: rv.e = 8'hFE;
            2: rv.e = 8'hFF;
            default: rv.e = 8'($urandom);
          endcase
          rv.f  = 12'($urandom);
          rv.tr = ($urandom_range(0, 7) != 0);
          rv.ov = ($urandom_range(0, 7) == 0);
          rv.un = ($urandom_range(0, 7) == 0);
          set_in(rv, 1'b1);
        end else begin
          valid_i = 1'b0;
        end
        ready_i = ($urandom_range(0, 3) != 0);
        #1;
        if (valid_o && ready_i) begin
          if (q.size() == 0) check("rnd_unexpected_out", 32'(valid_o), 32'h0);
          else check($sformatf("rnd_out%0d", n_out), 32'(res_o), 32'(q.pop_front()));
          n_out++;
        end
        if (valid_i && ready_o) begin
          model(s_i, e_i, f_i, isToRound_i, isOverflow_i, isUnderflow_i, exp_res, exp_flg);
          q.push_back(exp_res);
          acc_flg = acc_flg | exp_flg;
          n_in++;
        end
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (2) @(negedge clk);
      check("rnd_inputs_sent", 32'(n_in), 32'd300);
      check("rnd_outputs_seen", 32'(n_out), 32'(n_in));
      check("rnd_queue_empty", 32'(q.size()), 32'd0);
      check("rnd_sticky_flags", 32'(flags_o), 32'(acc_flg));
    end

    // Reset while a result is held on the output and another sits in stage 1.
    begin
      int n;
      @(negedge clk);
      ready_i = 1'b0;
      set_in(tbl[1], 1'b1);
      @(negedge clk);
      set_in(tbl[2], 1'b1);
      @(negedge clk);
      valid_i = 1'b0;
      check("rst6_held_res", 32'(res_o), 32'(tbl[1].res));
      @(negedge clk);
      check("rst6_stable_res", 32'(res_o), 32'(tbl[1].res));
      check("rst6_stable_valid", 32'(valid_o), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check("rst6_valid_dropped", 32'(valid_o), 32'h0);
      check("rst6_res_zero", 32'(res_o), 32'h0);
      check("rst6_flags_zero", 32'(flags_o), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      ready_i = 1'b1;
      #1;
      check("rst6_ready_after", 32'(ready_o), 32'h1);
      @(negedge clk);
      set_in(tbl[9], 1'b1);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      n = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (valid_o) begin
          check("rst6_new_res", 32'(res_o), 32'(tbl[9].res));
          n++;
        end
      end
      check("rst6_single_output", 32'(n), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
